conv_layer_2_streamer: RTL and testbench
========================================

# conv_layer_2_streamer

Input-side feeder for `conv_layer_2_kernal`. Captures the six 12×12 layer-1 feature maps (six 16-bit channels, written in parallel one pixel per cycle) into six internal 144-entry buffers. On `start`, it replays them as a contiguous 144-cycle stream on `image_kernal_1..6` with `valid`. It then waits for the kernel's `finish` before accepting the next frame. It sits between the layer-1 output and the layer-2 kernel in the conv pipeline.

## Interface
Parameters:
- `DATA_W`, 16, pixel width per channel.
- `PIXELS`, 144, pixels per feature map (12×12); legal range 1..256.

Ports:
- `clk_global`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  one pixel of all six channels presented this cycle.
- `load_data_1` .. `load_data_6`  in  DATA_W each  channel pixels, written at the current fill address.
- `load_ready`  out  1  high while the block accepts pixels (FILL state).
- `start`  in  1  single-cycle request to stream the stored frame.
- `finish`  in  1  from `conv_layer_2_kernal`; the kernel has completed the frame.
- `image_kernal_1` .. `image_kernal_6`  out  DATA_W each  streamed pixels; drive to the kernel.
- `valid`  out  1  high on exactly the cycles carrying stream pixels.
- `done`  out  1  one-cycle pulse when `finish` is accepted.

## Operation
- Storage: six arrays of PIXELS×DATA_W. One 8-bit address counter is shared by fill and stream.
- Outputs are registered. Reset values: `load_ready`=1, `valid`=0, `done`=0, `image_kernal_*`=0. On reset, the state becomes FILL and the counter returns to 0. Buffer contents are not cleared.
- FILL:
  - `load_ready`=1.
  - Each `load_valid` writes all six channels at `addr`, then increments `addr`.
  - The write at `addr`=PIXELS-1 moves to READY, clears `addr`, and drops `load_ready` on the next cycle.
  - `start` is ignored in FILL.
- READY:
  - Holds the frame; `load_valid` is ignored.
  - `start`=1 moves to STREAM.
- STREAM:
  - Each cycle, `image_kernal_n` is loaded with buffer_n[`addr`] and `valid` is set to 1. `addr` increments.
  - After PIXELS pixels, moves to WAIT_FIN with `addr`=0.
  - No backpressure: the stream is never paused.
  - `start` and `load_valid` are ignored.
- WAIT_FIN:
  - `valid`=0 and `image_kernal_*`=0.
  - `finish`=1 pulses `done` and returns to FILL (see Configuration).
  - `finish` is sampled only in WAIT_FIN; `finish` asserted during FILL, READY or STREAM is ignored.
- Stream arithmetic: pure pass-through. No sign handling and no width change.

## Timing
- Fill: the pixel presented at edge k is stored at the address current at edge k. A full frame needs exactly PIXELS accepted `load_valid` cycles; gaps are allowed.
- Start latency: with `start` sampled high in READY at edge t, pixel i is present with `valid`=1 during the cycle following edge t+1+i, for i = 0..PIXELS-1.
- `valid` is low during the cycle following edge t+1+PIXELS.
- `valid` is never high for more than PIXELS consecutive cycles per `start`.
- `done` is high for the single cycle following the edge at which `finish` is sampled in WAIT_FIN. `load_ready`=1 rises on that same cycle.
- Reset mid-operation: the cycle after the reset edge shows reset values regardless of state. A partial stream is abandoned.
- `start` and `finish` on the same edge: only the one relevant to the current state acts.

## Configuration
- `CONV2_STREAM_REPLAY_EN` defined:
  - Adds input `reload` (1 bit).
  - After `finish`, the block returns to READY instead of FILL, keeping the frame so `start` can stream it again.
  - In READY, `reload`=1 moves to FILL with `addr`=0.
  - If `reload` and `start` are both high on the same READY edge, `start` wins.
- Undefined: the `reload` port is absent and WAIT_FIN always returns to FILL.

## Test plan
- Fill with ch n pixel i = n·256+i (PIXELS=144), then pulse `start`: expect 144 consecutive `valid` cycles with `image_kernal_n` = n·256+i in order, first one two edges after `start`, and `valid`=0 on the 145th cycle.
- Pulse `start` during FILL at `addr`=40, and drive 10 extra `load_valid` cycles in READY: expect no stream and no change to the buffer. A subsequent `start` streams the original ramp.
- `finish` during STREAM is ignored. `finish` in WAIT_FIN gives `done`=1 for exactly one cycle and `load_ready`=1 on the same cycle.
- `reset` at stream pixel 50: next cycle `valid`=0, `image_kernal_*`=0, `load_ready`=1. A fresh 144-pixel fill (values +1000) plus `start` streams the new values from pixel 0.
- Gapped fill (`load_valid` every third cycle): `load_ready` drops only after the 144th accepted pixel.
- With `CONV2_STREAM_REPLAY_EN`: fill, stream, `finish`, then `start` again restreams the identical frame. `reload` returns the block to FILL with `load_ready`=1.

Source files
------------

// File: rtl/conv_layer_2_streamer.sv
// conv_layer_2_streamer
//
// Input-side feeder for conv_layer_2_kernal. Captures six 12x12 layer-1
// feature maps (one pixel of all six channels per accepted cycle) into six
// internal PIXELS-deep buffers. On start it replays the stored frame as a
// gap-free PIXELS-cycle stream. It then waits for the kernel's finish before
// accepting the next frame.
//
// Optional feature macro: CONV2_STREAM_REPLAY_EN
//   When defined, adds input 'reload'. After finish the block returns to READY
//   (frame kept, so start can replay it). In READY, reload returns to FILL, and
//   start takes priority over reload.
//
// Ports:
//   clk_global                    in   single clock, rising edge
//   reset                         in   synchronous, active-high
//   load_valid                    in   one pixel of all six channels this cycle
//   load_data_1..6                in   channel pixels written at the fill address
//   load_ready                    out  high while in FILL
//   start                         in   request to stream the stored frame
//   finish                        in   kernel has completed the frame
//   reload                        in   (replay build only) back to FILL from READY
//   image_kernal_1..6             out  streamed pixels
//   valid                         out  high on cycles carrying stream pixels
//   done                          out  one-cycle pulse when finish is accepted
module conv_layer_2_streamer #(
    parameter int DATA_W = 16,
    parameter int PIXELS = 144
) (
    input  logic              clk_global,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data_1,
    input  logic [DATA_W-1:0] load_data_2,
    input  logic [DATA_W-1:0] load_data_3,
    input  logic [DATA_W-1:0] load_data_4,
    input  logic [DATA_W-1:0] load_data_5,
    input  logic [DATA_W-1:0] load_data_6,
    output logic              load_ready,
    input  logic              start,
    input  logic              finish,
`ifdef CONV2_STREAM_REPLAY_EN
    input  logic              reload,
`endif
    output logic [DATA_W-1:0] image_kernal_1,
    output logic [DATA_W-1:0] image_kernal_2,
    output logic [DATA_W-1:0] image_kernal_3,
    output logic [DATA_W-1:0] image_kernal_4,
    output logic [DATA_W-1:0] image_kernal_5,
    output logic [DATA_W-1:0] image_kernal_6,
    output logic              valid,
    output logic              done
);

    localparam int         AW   = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [7:0] LAST = 8'(PIXELS - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_READY,
        S_STREAM,
        S_WAIT_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic              load_ready_q, load_ready_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] img_q [6];
    logic [DATA_W-1:0] img_d [6];
    logic              wr_en;
    logic [DATA_W-1:0] wr_data [6];

    // Frame storage; contents deliberately survive reset.
    logic [DATA_W-1:0] buf_q [6][PIXELS];

    // Only the low AW bits address the buffers; addr never exceeds PIXELS-1.
    logic [AW-1:0]     addr_idx;
    assign addr_idx = addr_q[AW-1:0];

    assign wr_data[0] = load_data_1;
    assign wr_data[1] = load_data_2;
    assign wr_data[2] = load_data_3;
    assign wr_data[3] = load_data_4;
    assign wr_data[4] = load_data_5;
    assign wr_data[5] = load_data_6;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        for (int n = 0; n < 6; n++) img_d[n] = '0;

        case (state_q)
            S_FILL: begin
                if (load_valid) begin
                    wr_en = 1'b1;
                    if (addr_q == LAST) begin
                        state_d = S_READY;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 8'd1;
                    end
                end
            end
            S_READY: begin
                if (start) begin
                    state_d = S_STREAM;
                    addr_d  = '0;
                end
`ifdef CONV2_STREAM_REPLAY_EN
                else if (reload) begin
                    state_d = S_FILL;
                    addr_d  = '0;
                end
`endif
            end
            S_STREAM: begin
                valid_d = 1'b1;
                for (int n = 0; n < 6; n++) img_d[n] = buf_q[n][addr_idx];
                if (addr_q == LAST) begin
                    state_d = S_WAIT_FIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 8'd1;
                end
            end
            S_WAIT_FIN: begin
                if (finish) begin
                    done_d = 1'b1;
`ifdef CONV2_STREAM_REPLAY_EN
                    state_d = S_READY;
`else
                    state_d = S_FILL;
`endif
                end
            end
            default: begin
                state_d = S_FILL;
                addr_d  = '0;
            end
        endcase

        // Registered from the next state so it tracks FILL with no extra lag.
        load_ready_d = (state_d == S_FILL);
    end

    always_ff @(posedge clk_global) begin
        if (reset) begin
            state_q      <= S_FILL;
            addr_q       <= '0;
            load_ready_q <= 1'b1;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            for (int n = 0; n < 6; n++) img_q[n] <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            load_ready_q <= load_ready_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            for (int n = 0; n < 6; n++) img_q[n] <= img_d[n];
        end
    end

    always_ff @(posedge clk_global) begin
        if (wr_en) begin
            for (int n = 0; n < 6; n++) buf_q[n][addr_idx] <= wr_data[n];
        end
    end

    assign load_ready     = load_ready_q;
    assign valid          = valid_q;
    assign done           = done_q;
    assign image_kernal_1 = img_q[0];
    assign image_kernal_2 = img_q[1];
    assign image_kernal_3 = img_q[2];
    assign image_kernal_4 = img_q[3];
    assign image_kernal_5 = img_q[4];
    assign image_kernal_6 = img_q[5];

endmodule

// File: tb/tb_conv_layer_2_streamer.sv
// Testbench for conv_layer_2_streamer: random and ramp frames, gapped fills,
// stray start/finish/load_valid, reset mid-stream, optional replay/reload.
module tb_conv_layer_2_streamer;

    localparam int DATA_W = 16;
    localparam int PIXELS = 144;

    logic              clk_global = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data_1, load_data_2, load_data_3;
    logic [DATA_W-1:0] load_data_4, load_data_5, load_data_6;
    logic              load_ready;
    logic              start;
    logic              finish;
    logic              reload;
    logic [DATA_W-1:0] image_kernal_1, image_kernal_2, image_kernal_3;
    logic [DATA_W-1:0] image_kernal_4, image_kernal_5, image_kernal_6;
    logic              valid;
    logic              done;

    int errs   = 0;
    int checks = 0;

    // Reference frame: what the stream must reproduce, channel by pixel.
    logic [DATA_W-1:0] mdl [6][PIXELS];

    always #5 clk_global = ~clk_global;

    conv_layer_2_streamer #(.DATA_W(DATA_W), .PIXELS(PIXELS)) dut (
        .clk_global     (clk_global),
        .reset          (reset),
        .load_valid     (load_valid),
        .load_data_1    (load_data_1),
        .load_data_2    (load_data_2),
        .load_data_3    (load_data_3),
        .load_data_4    (load_data_4),
        .load_data_5    (load_data_5),
        .load_data_6    (load_data_6),
        .load_ready     (load_ready),
        .start          (start),
        .finish         (finish),
`ifdef CONV2_STREAM_REPLAY_EN
        .reload         (reload),
`endif
        .image_kernal_1 (image_kernal_1),
        .image_kernal_2 (image_kernal_2),
        .image_kernal_3 (image_kernal_3),
        .image_kernal_4 (image_kernal_4),
        .image_kernal_5 (image_kernal_5),
        .image_kernal_6 (image_kernal_6),
        .valid          (valid),
        .done           (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_global);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] img(input int n);
        case (n)
            0: return image_kernal_1;
            1: return image_kernal_2;
            2: return image_kernal_3;
            3: return image_kernal_4;
            4: return image_kernal_5;
            default: return image_kernal_6;
        endcase
    endfunction

    task automatic drive_data(input logic [DATA_W-1:0] v [6]);
        load_data_1 = v[0]; load_data_2 = v[1]; load_data_3 = v[2];
        load_data_4 = v[3]; load_data_5 = v[4]; load_data_6 = v[5];
    endtask

    task automatic drive_random();
        logic [DATA_W-1:0] v [6];
        for (int n = 0; n < 6; n++) v[n] = DATA_W'($urandom);
        drive_data(v);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        for (int n = 0; n < 6; n++) check({tag, "_img"}, 32'(img(n)), 32'd0);
    endtask

    // mode 0: ramp (ch n+1)*256 + i + off; mode 1: random.
    // gap < 0 means random 0..2 idle cycles before each pixel.
    // start is pulsed alongside pixel start_at to show it is ignored in FILL.
    task automatic fill_frame(input int mode, input int off, input int gap, input int start_at);
        logic [DATA_W-1:0] v [6];
        int g;
        for (int i = 0; i < PIXELS; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                load_valid = 1'b0;
                drive_random();
                step();
                check("fill_gap_ready", 32'(load_ready), 32'd1);
            end
            for (int n = 0; n < 6; n++) begin
                v[n] = (mode == 0) ? DATA_W'((n + 1) * 256 + i + off) : DATA_W'($urandom);
                mdl[n][i] = v[n];
            end
            drive_data(v);
            load_valid = 1'b1;
            start      = (i == start_at);
            step();
            check("fill_ready", 32'(load_ready), (i == PIXELS - 1) ? 32'd0 : 32'd1);
            check("fill_valid", 32'(valid), 32'd0);
        end
        load_valid = 1'b0;
        start      = 1'b0;
    endtask

    // load_valid and finish while holding a frame must leave everything alone.
    task automatic stray_inputs(input int k);
        for (int c = 0; c < k; c++) begin
            drive_random();
            load_valid = 1'b1;
            finish     = (c == 0);
            step();
            check("ready_lr", 32'(load_ready), 32'd0);
            check("ready_done", 32'(done), 32'd0);
            check("ready_valid", 32'(valid), 32'd0);
        end
        load_valid = 1'b0;
        finish     = 1'b0;
    endtask

    // Returns 1 in aborted if reset was applied after pixel reset_at.
    task automatic stream_frame(input int fin_at, input int reset_at, output bit aborted);
        aborted = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_lat_valid", 32'(valid), 32'd0);
        for (int i = 0; i < PIXELS; i++) begin
            finish = (i == fin_at);
            if (($urandom & 1) == 1) start = 1'b1;
            step();
            start = 1'b0;
            check("strm_valid", 32'(valid), 32'd1);
            for (int n = 0; n < 6; n++) check("strm_img", 32'(img(n)), 32'(mdl[n][i]));
            if (i == reset_at) begin
                finish = 1'b0;
                reset  = 1'b1;
                step();
                reset  = 1'b0;
                check_idle_outputs("rst_mid");
                check("rst_mid_lr", 32'(load_ready), 32'd1);
                check("rst_mid_done", 32'(done), 32'd0);
                aborted = 1'b1;
                return;
            end
        end
        finish = 1'b0;
        step();
        check_idle_outputs("strm_tail");
        check("strm_tail_done", 32'(done), 32'd0);
    endtask

    task automatic wait_fin();
        int w;
        w = int'($urandom_range(0, 3));
        for (int c = 0; c < w; c++) begin
            step();
            check("wf_done", 32'(done), 32'd0);
            check("wf_lr", 32'(load_ready), 32'd0);
            check("wf_valid", 32'(valid), 32'd0);
        end
        finish = 1'b1;
        step();
        finish = 1'b0;
        check("fin_done", 32'(done), 32'd1);
`ifdef CONV2_STREAM_REPLAY_EN
        check("fin_lr", 32'(load_ready), 32'd0);
`else
        check("fin_lr", 32'(load_ready), 32'd1);
`endif
        step();
        check("fin_done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        bit ab;
        reset = 1'b1; load_valid = 1'b0; start = 1'b0; finish = 1'b0; reload = 1'b0;
        drive_random();
        step();
        step();
        reset = 1'b0;
        check_idle_outputs("reset");
        check("reset_lr", 32'(load_ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);

        // Ramp frame, start ignored during fill, stray inputs while READY,
        // finish ignored mid-stream.
        fill_frame(0, 0, 0, 40);
        stray_inputs(10);
        stream_frame(60, -1, ab);
        wait_fin();

`ifdef CONV2_STREAM_REPLAY_EN
        // Replay the same frame, then reload back to FILL.
        stream_frame(-1, -1, ab);
        wait_fin();
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("reload_lr", 32'(load_ready), 32'd1);
        check("reload_valid", 32'(valid), 32'd0);
`endif

        // Random frame, abandoned by reset at pixel 50.
        fill_frame(1, 0, -1, -1);
        stream_frame(-1, 50, ab);
        check("rst_aborted", 32'(ab), 32'd1);

        // Fresh ramp +1000 with load_valid every third cycle.
        fill_frame(0, 1000, 2, -1);
        stream_frame(-1, -1, ab);
        wait_fin();
`ifdef CONV2_STREAM_REPLAY_EN
        reload = 1'b1;
        step();
        reload = 1'b0;
`endif

        // Random frames with random gaps.
        for (int f = 0; f < 2; f++) begin
            fill_frame(1, 0, -1, int'($urandom_range(0, PIXELS - 1)));
            stray_inputs(3);
            stream_frame(int'($urandom_range(0, PIXELS - 1)), -1, ab);
            wait_fin();
`ifdef CONV2_STREAM_REPLAY_EN
            reload = 1'b1;
            step();
            reload = 1'b0;
`endif
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
